// File: rtl/sim_exit_monitor.sv
// Store-bus monitor that decides when a test program has ended and whether it passed.
// Also keeps a rotate-XOR store signature plus store and cycle counters for regression.
module sim_exit_monitor #(
    parameter logic [31:0] HALT_ADDR      = 32'h000000bc,
    parameter logic [31:0] RESULT_ADDR    = 32'h00000400,
    parameter logic [31:0] TOHOST_ADDR    = 32'h00000ffc,
    parameter logic [31:0] EXPECTED       = 32'h00fff05f,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic [31:0] PC,
    output logic [1:0]  status,
    output logic        done,
    output logic [31:0] result,
    output logic        result_valid,
    output logic [30:0] fail_code,
    output logic [31:0] signature,
    output logic [15:0] store_count,
    output logic [31:0] cycle_count
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StPass    = 2'b01,
        StFail    = 2'b10,
        StTimeout = 2'b11
    } state_e;

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        result_valid_q, result_valid_d;
    logic [30:0] fail_code_q, fail_code_d;
    logic [31:0] signature_q, signature_d;
    logic [15:0] store_count_q, store_count_d;
    logic [31:0] cycle_count_q, cycle_count_d;

    logic accept, result_hit, tohost_hit, halt_hit;

    assign accept     = MemWrite && (state_q == StRun);
    assign result_hit = accept && (DataAdr == RESULT_ADDR);
    assign tohost_hit = accept && (DataAdr == TOHOST_ADDR);
    assign halt_hit   = (state_q == StRun) && (PC == HALT_ADDR);

    always_comb begin
        state_d        = state_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        fail_code_d    = fail_code_q;
        signature_d    = signature_q;
        store_count_d  = store_count_q;
        cycle_count_d  = cycle_count_q;

        if (state_q == StRun) begin
            cycle_count_d = cycle_count_q + 32'd1;

            if (accept) begin
                signature_d = {signature_q[30:0], signature_q[31]} ^ WriteData;
                if (store_count_q != 16'hFFFF) begin
                    store_count_d = store_count_q + 16'd1;
                end
            end

            // result_d already carries a same-cycle RESULT_ADDR store, giving the halt bypass.
            if (result_hit) begin
                result_d       = WriteData;
                result_valid_d = 1'b1;
            end

            if (tohost_hit) begin
                if (WriteData == 32'd1) begin
                    state_d = StPass;
                end else begin
                    state_d     = StFail;
                    fail_code_d = WriteData[31:1];
                end
            end else if (halt_hit) begin
                if (result_valid_d && (result_d == EXPECTED)) begin
                    state_d = StPass;
                end else begin
                    state_d = StFail;
                end
            end else if (cycle_count_q == TimeoutLast) begin
                state_d = StTimeout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StRun;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            fail_code_q    <= '0;
            signature_q    <= '0;
            store_count_q  <= '0;
            cycle_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            fail_code_q    <= fail_code_d;
            signature_q    <= signature_d;
            store_count_q  <= store_count_d;
            cycle_count_q  <= cycle_count_d;
        end
    end

    assign status       = state_q;
    assign done         = (state_q != StRun);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign fail_code    = fail_code_q;
    assign signature    = signature_q;
    assign store_count  = store_count_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Bench for sim_exit_monitor: directed program scenarios plus randomized store/PC traffic,
// checked every cycle against a rule-level model of the monitor.
module tb_sim_exit_monitor;

    localparam logic [31:0] HALT    = 32'h000000bc;
    localparam logic [31:0] RES     = 32'h00000400;
    localparam logic [31:0] TOHOST  = 32'h00000ffc;
    localparam logic [31:0] EXP     = 32'h00fff05f;
    localparam int unsigned TO      = 120;
    localparam logic [31:0] OTHER   = 32'h00000100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] PC = '0;
    logic [1:0]  status;
    logic        done;
    logic [31:0] result;
    logic        result_valid;
    logic [30:0] fail_code;
    logic [31:0] signature;
    logic [15:0] store_count;
    logic [31:0] cycle_count;

    sim_exit_monitor #(
        .HALT_ADDR      (HALT),
        .RESULT_ADDR    (RES),
        .TOHOST_ADDR    (TOHOST),
        .EXPECTED       (EXP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .PC           (PC),
        .status       (status),
        .done         (done),
        .result       (result),
        .result_valid (result_valid),
        .fail_code    (fail_code),
        .signature    (signature),
        .store_count  (store_count),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Model state: what the monitor must report, derived from the rules alone.
    logic [1:0]  m_status = '0;
    logic [31:0] m_result = '0;
    logic        m_valid = 1'b0;
    logic [30:0] m_fail = '0;
    logic [31:0] m_sig = '0;
    int unsigned m_stores = 0;
    int unsigned m_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic mw, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] pc);
        int unsigned old_cycles;
        if (r) begin
            m_status = 2'd0; m_result = '0; m_valid = 1'b0; m_fail = '0;
            m_sig = '0; m_stores = 0; m_cycles = 0;
        end else if (m_status == 2'd0) begin
            old_cycles = m_cycles;
            m_cycles = m_cycles + 1;
            if (mw) begin
                m_sig = ((m_sig << 1) | (m_sig >> 31)) ^ wd;
                if (m_stores < 65535) m_stores = m_stores + 1;
                if (a == RES) begin
                    m_result = wd;
                    m_valid = 1'b1;
                end
            end
            if (mw && a == TOHOST) begin
                if (wd == 32'd1) m_status = 2'd1;
                else begin
                    m_status = 2'd2;
                    m_fail = wd[31:1];
                end
            end else if (pc == HALT) begin
                m_status = (m_valid && m_result == EXP) ? 2'd1 : 2'd2;
            end else if (old_cycles == TO - 1) begin
                m_status = 2'd3;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic mw, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pc);
        reset = r; MemWrite = mw; DataAdr = a; WriteData = wd; PC = pc;
        @(posedge clk);
        model_step(r, mw, a, wd, pc);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, OTHER, 32'h0, 32'h00000010);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, '0, '0, HALT);
        cyc(1'b1, 1'b1, TOHOST, 32'd1, HALT);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("status", {30'd0, status}, {30'd0, m_status});
            chk("done", {31'd0, done}, {31'd0, (m_status != 2'd0)});
            chk("result", result, m_result);
            chk("result_valid", {31'd0, result_valid}, {31'd0, m_valid});
            chk("fail_code", {1'b0, fail_code}, {1'b0, m_fail});
            chk("signature", signature, m_sig);
            chk("store_count", {16'd0, store_count}, m_stores);
            chk("cycle_count", cycle_count, m_cycles);
        end
    end

    initial begin
        logic [31:0] a, wd, pc;
        logic mw, r;
        int k;

        do_reset();
        cmp_en = 1'b1;
        chk("rst_status", {30'd0, status}, 32'd0);
        chk("rst_signature", signature, 32'd0);

        // Normal program: result store at cycle 10, halt at cycle 40.
        idle(10);
        cyc(1'b0, 1'b1, RES, EXP, 32'h00000010);
        idle(29);
        chk("halt_pre_status", {30'd0, status}, 32'd0);
        cyc(1'b0, 1'b0, OTHER, 32'h0, HALT);
        chk("halt_status", {30'd0, status}, 32'd1);
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_result", result, EXP);
        chk("halt_stores", {16'd0, store_count}, 32'd1);
        chk("halt_cycles", cycle_count, 32'd41);

        // Last RESULT store wins.
        do_reset();
        cyc(1'b0, 1'b1, RES, 32'd5, 32'h10);
        cyc(1'b0, 1'b1, RES, EXP, 32'h14);
        cyc(1'b0, 1'b0, OTHER, 32'h0, HALT);
        chk("lastwin_pass", {30'd0, status}, 32'd1);
        do_reset();
        cyc(1'b0, 1'b1, RES, EXP, 32'h10);
        cyc(1'b0, 1'b1, RES, 32'd5, 32'h14);
        cyc(1'b0, 1'b0, OTHER, 32'h0, HALT);
        chk("lastwin_fail", {30'd0, status}, 32'd2);
        chk("lastwin_code", {1'b0, fail_code}, 32'd0);
        chk("lastwin_result", result, 32'd5);

        // TOHOST fail, then terminal state ignores everything.
        do_reset();
        cyc(1'b0, 1'b1, TOHOST, 32'h0000000B, 32'h10);
        chk("tohost_fail", {30'd0, status}, 32'd2);
        chk("tohost_code", {1'b0, fail_code}, 32'd5);
        cyc(1'b0, 1'b1, TOHOST, 32'd1, HALT);
        chk("sticky_status", {30'd0, status}, 32'd2);
        chk("sticky_stores", {16'd0, store_count}, 32'd1);

        // TOHOST beats HALT; halt-cycle result store is bypassed.
        do_reset();
        cyc(1'b0, 1'b1, TOHOST, 32'd1, HALT);
        chk("prio_pass", {30'd0, status}, 32'd1);
        do_reset();
        idle(3);
        cyc(1'b0, 1'b1, RES, EXP, HALT);
        chk("bypass_pass", {30'd0, status}, 32'd1);

        // Timeout after exactly TO running cycles.
        do_reset();
        idle(TO - 1);
        chk("to_pre", {30'd0, status}, 32'd0);
        idle(1);
        chk("to_status", {30'd0, status}, 32'd3);
        chk("to_cycles", cycle_count, TO);
        idle(10);
        chk("to_frozen", cycle_count, TO);

        // Signature hashing and mid-run reset.
        do_reset();
        cyc(1'b0, 1'b1, OTHER, 32'h1, 32'h10);
        chk("sig1", signature, 32'h1);
        cyc(1'b0, 1'b1, OTHER, 32'h2, 32'h14);
        chk("sig2", signature, 32'h0);
        cyc(1'b0, 1'b1, OTHER, 32'h80000000, 32'h18);
        chk("sig3", signature, 32'h80000000);
        cyc(1'b1, 1'b0, OTHER, 32'h0, HALT);
        chk("midrst_stores", {16'd0, store_count}, 32'd0);
        chk("midrst_sig", signature, 32'd0);
        cyc(1'b0, 1'b1, RES, EXP, 32'h10);
        cyc(1'b0, 1'b0, OTHER, 32'h0, HALT);
        chk("resume_pass", {30'd0, status}, 32'd1);

        // Randomized traffic, every cycle checked by the compare process.
        for (int run = 0; run < 30; run++) begin
            do_reset();
            for (int i = 0; i < 200; i++) begin
                r  = ($urandom % 150) == 0;
                mw = ($urandom % 3) == 0;
                k  = $urandom % 16;
                a  = (k < 6) ? RES : (k == 6) ? TOHOST : (32'h100 + ($urandom % 64) * 4);
                k  = $urandom % 8;
                wd = (k == 0) ? 32'd1 : (k < 3) ? EXP : (k == 3) ? 32'd0 : $urandom;
                pc = (($urandom % 40) == 0) ? HALT : ($urandom & 32'hfffffffc);
                if (pc == HALT && ($urandom % 40) != 0) pc = pc ^ 32'h4;
                cyc(r, mw, a, wd, pc);
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
